// File: rtl/timer_tick_gen.sv
// timer_tick_gen -- count-enable source for the 8-bit timer counter.
//
// Chooses between an internal power-of-two prescaler and an external event
// pin. It emits a registered, single-cycle o_tick, and the counter advances
// only on that pulse. All synchronisation and edge detection for the
// asynchronous event pin happens here, so the counter stays purely
// synchronous.
//
// Optional build macro: TIMER_EVENT_FILTER_EN inserts a glitch filter after
// the synchronizer. It is off by default and no filter logic exists then.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on i_timer_event (2..4)
//   FILTER_LEN   consecutive equal samples needed to accept a level change
//                (1..15, only meaningful with TIMER_EVENT_FILTER_EN)
//
// Ports:
//   i_clk          system clock
//   rst_n          asynchronous active-low reset
//   i_enable       tick generation allowed
//   i_clk_control  [3] 0=internal, 1=external
//                  internal: [2:0] -> divisor 2^n
//                  external: [1:0] 00 rise, 01 fall, 10 both, 11 none
//   i_timer_event  asynchronous external event pin
//   o_tick         one-cycle count-enable pulse
//   o_event_sync   synchronized (and filtered) event level
//   o_prescale_cnt internal prescaler value (debug)
module timer_tick_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       i_clk,
  input  logic       rst_n,
  input  logic       i_enable,
  input  logic [3:0] i_clk_control,
  input  logic       i_timer_event,
  output logic       o_tick,
  output logic       o_event_sync,
  output logic [7:0] o_prescale_cnt
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_param
    $error("timer_tick_gen: SYNC_STAGES or FILTER_LEN out of range");
  end

  // Edge detection stays blind until the event path has flushed the values
  // it loaded during reset. A pin held high through reset then produces no
  // tick.
`ifdef TIMER_EVENT_FILTER_EN
  localparam int ARM_CYC = SYNC_STAGES + FILTER_LEN + 1;
`else
  localparam int ARM_CYC = SYNC_STAGES + 1;
`endif

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ev_lvl;
  logic                   ev_prev_q;
  logic [ARM_CYC-1:0]     arm_q;
  logic [3:0]             cfg_q;
  logic                   cfg_vld_q;
  logic [7:0]             prescale_q, prescale_d;
  logic                   tick_q, tick_d;
  logic [7:0]             div_m1;
  logic                   cfg_chg;
  logic                   armed;
  logic                   edge_hit;

`ifdef TIMER_EVENT_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic [FCW-1:0] fcnt_q;
  logic           filt_q;

  // The filtered level flips only after FILTER_LEN consecutive cycles that
  // disagree with it. Any agreeing sample, or a disable, restarts the run.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else if (!i_enable || (sync_q[SYNC_STAGES-1] == filt_q)) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
      fcnt_q <= '0;
      filt_q <= sync_q[SYNC_STAGES-1];
    end else begin
      fcnt_q <= fcnt_q + FCW'(1);
    end
  end

  assign ev_lvl = filt_q;
`else
  assign ev_lvl = sync_q[SYNC_STAGES-1];
`endif

  // N-1 for N = 2^sel. The largest value is 127, so it fits in 8 bits.
  assign div_m1 = (8'd1 << i_clk_control[2:0]) - 8'd1;

  // The first cycle after reset only loads the config copy and does not
  // count as a change. The prescaler therefore starts counting immediately.
  assign cfg_chg = cfg_vld_q && (i_clk_control != cfg_q);
  assign armed   = arm_q[ARM_CYC-1];

  always_comb begin
    edge_hit = 1'b0;
    case (i_clk_control[1:0])
      2'b00:   edge_hit = ev_lvl & ~ev_prev_q;
      2'b01:   edge_hit = ~ev_lvl & ev_prev_q;
      2'b10:   edge_hit = ev_lvl ^ ev_prev_q;
      default: edge_hit = 1'b0;
    endcase
  end

  // A disable or a config change outranks both a terminal count and an
  // edge. Either one clears the prescaler and drops the tick.
  always_comb begin
    prescale_d = '0;
    tick_d     = 1'b0;
    if (i_enable && !cfg_chg) begin
      if (!i_clk_control[3]) begin
        if (prescale_q == div_m1) tick_d = 1'b1;
        else                      prescale_d = prescale_q + 8'd1;
      end else begin
        tick_d = armed & edge_hit;
      end
    end
  end

  // The synchronizer and edge history keep running while disabled, so
  // re-enabling does not see a stale edge.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      ev_prev_q  <= 1'b0;
      arm_q      <= '0;
      cfg_q      <= '0;
      cfg_vld_q  <= 1'b0;
      prescale_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], i_timer_event};
      ev_prev_q  <= ev_lvl;
      arm_q      <= {arm_q[ARM_CYC-2:0], 1'b1};
      cfg_q      <= i_clk_control;
      cfg_vld_q  <= 1'b1;
      prescale_q <= prescale_d;
      tick_q     <= tick_d;
    end
  end

  assign o_tick         = tick_q;
  assign o_event_sync   = ev_lvl;
  assign o_prescale_cnt = prescale_q;

endmodule

// File: tb/tb_timer_tick_gen.sv
// Randomized and directed bench for timer_tick_gen (default build, no filter).
// The reference model keeps a history of sampled pin values and a run-length
// counter since the last restart. The expected prescaler is run mod N. The
// external path compares pin samples delayed by the synchronizer depth.
module tb_timer_tick_gen;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [3:0] ctrl = 4'b1000;
  logic       pin = 1'b1;
  logic       o_tick, o_event_sync;
  logic [7:0] o_prescale_cnt;

  always #20 clk = ~clk;

  timer_tick_gen #(.SYNC_STAGES(S), .FILTER_LEN(3)) dut (
    .i_clk          (clk),
    .rst_n          (rst_n),
    .i_enable       (en),
    .i_clk_control  (ctrl),
    .i_timer_event  (pin),
    .o_tick         (o_tick),
    .o_event_sync   (o_event_sync),
    .o_prescale_cnt (o_prescale_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // reference model state
  int         ecnt;       // clock edges since reset release
  bit         pq[$];      // pin value sampled at edge k -> pq[k-1]
  bit         have_prev;
  logic [3:0] prev_ctrl;
  int         run;        // enabled, unchanged-config edges since restart
  bit         e_tick, e_sync;
  int         e_pres;
  int         ticks = 0;

  function automatic bit pin_at(input int k);
    if (k < 1 || k > ecnt) return 1'b0;
    return pq[k-1];
  endfunction

  function automatic bit qual(input logic [1:0] sel, input bit cur, input bit prv);
    case (sel)
      2'b00:   return cur & ~prv;
      2'b01:   return ~cur & prv;
      2'b10:   return cur ^ prv;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    ecnt = 0; pq.delete(); have_prev = 0; run = 0;
    e_tick = 0; e_sync = 0; e_pres = 0;
  endtask

  task automatic step();
    bit chg;
    int n;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      ecnt++;
      pq.push_back(pin);
      chg = have_prev && (ctrl != prev_ctrl);
      prev_ctrl = ctrl;
      have_prev = 1;
      n = 1 << ctrl[2:0];
      if (!en || chg) begin
        run = 0; e_tick = 0; e_pres = 0;
      end else if (!ctrl[3]) begin
        run++;
        e_pres = run % n;
        e_tick = (run % n) == 0;
      end else begin
        run = 0; e_pres = 0;
        e_tick = (ecnt >= S + 2) && qual(ctrl[1:0], pin_at(ecnt - S), pin_at(ecnt - S - 1));
      end
      e_sync = pin_at(ecnt - S + 1);
    end
    #1;
    chk("tick", o_tick, e_tick);
    chk("event_sync", o_event_sync, e_sync);
    chk("prescale", o_prescale_cnt, e_pres);
    if (o_tick) ticks++;
  endtask

  initial begin
    int t0, first;
    model_reset();
    #5;
    chk("rst_tick", o_tick, 0);
    chk("rst_sync", o_event_sync, 0);
    chk("rst_pres", o_prescale_cnt, 0);
    step(); step();
    rst_n = 1'b1;

    // pin held high through reset: no tick, then one tick on the next rise
    t0 = ticks;
    repeat (10) step();
    chk("armed_hold_ticks", ticks - t0, 0);
    pin = 1'b0;
    repeat (4) step();
    pin = 1'b1;
    repeat (5) step();
    chk("first_rise_ticks", ticks - t0, 1);

    // internal divide by 8: 8 ticks in 64 cycles after the change cycle
    ctrl = 4'b0011;
    step();
    t0 = ticks;
    repeat (64) step();
    chk("div8_ticks", ticks - t0, 8);

    // external both edges, toggling every cycle
    ctrl = 4'b1010;
    step();
    t0 = ticks;
    for (int i = 0; i < 255; i++) begin
      pin = ~pin;
      step();
    end
    repeat (4) step();
    chk("both_edge_ticks", ticks - t0, 255);

    // config change at prescaler 100, then divide-by-1, then disable
    ctrl = 4'b0111;
    for (int i = 0; i < 400 && e_pres != 100; i++) step();
    chk("pres_at_switch", o_prescale_cnt, 100);
    ctrl = 4'b0000;
    step();
    t0 = ticks;
    repeat (5) step();
    chk("div1_ticks", ticks - t0, 5);
    en = 1'b0;
    step();
    en = 1'b1;

    // reset mid-count at divide by 128
    ctrl = 4'b0111;
    repeat (50) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_tick", o_tick, 0);
    chk("midrst_pres", o_prescale_cnt, 0);
    chk("midrst_sync", o_event_sync, 0);
    #27;
    rst_n = 1'b1;
    model_reset();
    first = -1;
    for (int i = 1; i <= 140; i++) begin
      step();
      if (o_tick && first < 0) first = i;
    end
    chk("first_tick_after_rst", first, 128);

    // random mix of modes, enables, pin activity and short resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 2) ctrl = 4'($urandom);
      if ($urandom_range(99) < 3) en = ~en;
      if ($urandom_range(99) < 30) pin = ~pin;
      if ($urandom_range(999) < 5) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
